fir_filter_mac: RTL and testbench

Parametrised successor to the fixed 4-tap FIR filter. It adds run-time programmable coefficients, valid/ready handshakes on input and output, and a single time-multiplexed multiply-accumulate unit. The output stage applies an arithmetic shift and saturates the result. It sits between a streaming sample source and a downstream consumer that may apply backpressure.

---
 rtl/fir_filter_mac.sv | 108 ++++++++++
 tb/tb_fir_filter_mac.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_filter_mac.sv
// Streaming FIR filter that walks the delay line with one shared multiply-accumulate unit.
// The shifted, saturated sum is held on y_out until the consumer accepts it.
module fir_filter_mac #(
    parameter int N_TAPS     = 8,
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     x_in,
    input  logic                      coef_we,
    input  logic [$clog2(N_TAPS)-1:0] coef_addr,
    input  logic [COEF_WIDTH-1:0]     coef_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_WIDTH-1:0]      y_out,
    output logic                      busy
);
    localparam int AW    = $clog2(N_TAPS);
    localparam int PW    = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W = PW + AW;
    localparam int EW    = ((ACC_W > OUT_WIDTH) ? ACC_W : OUT_WIDTH) + 1;
    localparam logic [AW:0] IDX_END = (AW+1)'(N_TAPS);
    localparam logic signed [EW-1:0] OMAX = {{(EW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0] OMIN = {{(EW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                 state;
    logic [DATA_WIDTH-1:0]  xline [N_TAPS];
    logic [COEF_WIDTH-1:0]  coef  [N_TAPS];
    logic signed [ACC_W-1:0] acc;
    logic [AW:0]            idx;
    logic [AW-1:0]          tap;
    logic signed [PW-1:0]   prod;
    logic signed [EW-1:0]   shifted;
    logic [OUT_WIDTH-1:0]   sat;

    // Shared product for the current tap, and the clamped view of the accumulator.
    always_comb begin
        tap     = idx[AW-1:0];
        prod    = PW'($signed(xline[tap])) * PW'($signed(coef[tap]));
        shifted = $signed({{(EW-ACC_W){acc[ACC_W-1]}}, acc}) >>> SHIFT;
        if (shifted > OMAX)
            sat = OMAX[OUT_WIDTH-1:0];
        else if (shifted < OMIN)
            sat = OMIN[OUT_WIDTH-1:0];
        else
            sat = shifted[OUT_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            y_out     <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            for (int k = 0; k < N_TAPS; k++) begin
                xline[k] <= '0;
                coef[k]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (coef_we)
                        coef[coef_addr] <= coef_data;
                    if (in_valid) begin
                        xline[0] <= x_in;
                        for (int k = 1; k < N_TAPS; k++)
                            xline[k] <= xline[k-1];
                        acc      <= '0;
                        idx      <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= MAC;
                    end
                end
                // One tap per cycle; the pass after the last tap only formats the sum.
                MAC: begin
                    if (idx == IDX_END) begin
                        y_out     <= sat;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        acc <= acc + ACC_W'(prod);
                        idx <= idx + 1'b1;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_filter_mac.sv
// Directed bench for fir_filter_mac: an arithmetic reference model is compared every cycle,
// and hand-computed results pin each scenario.
module tb_fir_filter_mac;
    localparam int N_TAPS     = 4;
    localparam int DATA_WIDTH = 8;
    localparam int COEF_WIDTH = 8;
    localparam int OUT_WIDTH  = 16;
    localparam int SHIFT      = 0;
    localparam int AW         = $clog2(N_TAPS);
    localparam longint OMAX   = (longint'(1) << (OUT_WIDTH-1)) - 1;
    localparam longint OMIN   = -(longint'(1) << (OUT_WIDTH-1));

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] x_in = '0;
    logic                  coef_we = 1'b0;
    logic [AW-1:0]         coef_addr = '0;
    logic [COEF_WIDTH-1:0] coef_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [OUT_WIDTH-1:0]  y_out;
    logic                  busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acceptCyc = 0;

    int hist [N_TAPS];
    int mc [N_TAPS];
    bit mBusy, mValid;
    int mCount, mExp, mY;

    fir_filter_mac #(
        .N_TAPS(N_TAPS), .DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH),
        .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready), .y_out(y_out), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Filter output straight from the definition: dot product, floor shift, clamp.
    function automatic int expectedOutput(input int newX, input bit we, input int wa, input int wd);
        longint sum, xs, c;
        sum = 0;
        for (int k = 0; k < N_TAPS; k++) begin
            xs = (k == 0) ? longint'(newX) : longint'(hist[k-1]);
            c  = (we && wa == k) ? longint'(wd) : longint'(mc[k]);
            sum += xs * c;
        end
        sum = sum >>> SHIFT;
        if (sum > OMAX) sum = OMAX;
        else if (sum < OMIN) sum = OMIN;
        return int'(sum);
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_TAPS; k++) begin
                hist[k] <= 0;
                mc[k]   <= 0;
            end
            mBusy  <= 1'b0;
            mValid <= 1'b0;
            mCount <= 0;
            mExp   <= 0;
            mY     <= 0;
        end else if (!mBusy) begin
            if (coef_we)
                mc[int'(coef_addr)] <= int'($signed(coef_data));
            if (in_valid) begin
                mExp <= expectedOutput(int'($signed(x_in)), coef_we, int'(coef_addr), int'($signed(coef_data)));
                hist[0] <= int'($signed(x_in));
                for (int k = 1; k < N_TAPS; k++)
                    hist[k] <= hist[k-1];
                mBusy  <= 1'b1;
                mCount <= 0;
            end
        end else if (!mValid) begin
            mCount <= mCount + 1;
            if (mCount + 1 == N_TAPS + 1) begin
                mValid <= 1'b1;
                mY     <= mExp;
            end
        end else if (out_ready) begin
            mValid <= 1'b0;
            mBusy  <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            compare("in_ready", int'(in_ready), int'(!mBusy));
            compare("busy", int'(busy), int'(mBusy));
            compare("out_valid", int'(out_valid), int'(mValid));
            compare("y_out", int'($signed(y_out)), mY);
        end
    end

    task automatic writeCoef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = AW'(addr);
        coef_data = COEF_WIDTH'(data);
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
    endtask

    task automatic applyStimulus(input int x, input bit we = 1'b0, input int wa = 0, input int wd = 0);
        in_valid  = 1'b1;
        x_in      = DATA_WIDTH'(x);
        coef_we   = we;
        coef_addr = AW'(wa);
        coef_data = COEF_WIDTH'(wd);
        for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept x=%0d: got in_ready=0 expected 1 within 40 cycles", x);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid  = 1'b0;
        coef_we   = 1'b0;
        acceptCyc = cyc;
    endtask

    task automatic checkOutput(input string name, input int exp);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s timeout: got out_valid=0 expected 1 within 40 cycles", name);
        end else begin
            compare({name, " latency"}, cyc - acceptCyc, N_TAPS + 1);
            compare(name, int'($signed(y_out)), exp);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] watchdog expired, CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] simulation timed out");
    end

    initial begin
        repeat (2) @(negedge clk);
        compare("reset y_out", int'($signed(y_out)), 0);
        compare("reset out_valid", int'(out_valid), 0);
        compare("reset in_ready", int'(in_ready), 1);
        compare("reset busy", int'(busy), 0);
        #2 rst = 1'b1;
        @(negedge clk);

        $display("[TB] moving sum, coefficients all 1");
        for (int k = 0; k < N_TAPS; k++) writeCoef(k, 1);
        applyStimulus(1); checkOutput("sum 1", 1);
        applyStimulus(2); checkOutput("sum 2", 3);
        applyStimulus(3); checkOutput("sum 3", 6);
        applyStimulus(4); checkOutput("sum 4", 10);
        applyStimulus(0); checkOutput("sum 5", 9);
        applyStimulus(0); checkOutput("sum 6", 7);

        $display("[TB] impulse response, coefficients 1..4");
        for (int k = 0; k < N_TAPS; k++) writeCoef(k, k + 1);
        applyStimulus(0); checkOutput("flush a1", 16);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0); checkOutput("flush a", 0);
        end
        applyStimulus(1); checkOutput("impulse 0", 1);
        applyStimulus(0); checkOutput("impulse 1", 2);
        applyStimulus(0); checkOutput("impulse 2", 3);
        applyStimulus(0); checkOutput("impulse 3", 4);
        applyStimulus(0); checkOutput("impulse 4", 0);

        $display("[TB] coefficient writes while busy and while idle");
        applyStimulus(1);
        coef_we = 1'b1; coef_addr = '0; coef_data = 8'd5;
        @(negedge clk);
        coef_we = 1'b0;
        checkOutput("busy write ignored", 1);
        applyStimulus(1); checkOutput("busy write later", 3);
        writeCoef(0, 5);
        applyStimulus(2); checkOutput("idle write", 15);
        applyStimulus(1, 1'b1, 0, 7); checkOutput("same-edge write", 18);

        $display("[TB] saturation, coefficients all 127");
        for (int k = 0; k < N_TAPS; k++) writeCoef(k, 127);
        applyStimulus(0); checkOutput("flush b1", 508);
        applyStimulus(0); checkOutput("flush b2", 381);
        applyStimulus(0); checkOutput("flush b3", 127);
        applyStimulus(0); checkOutput("flush b4", 0);
        applyStimulus(127); checkOutput("pos 1", 16129);
        applyStimulus(127); checkOutput("pos 2", 32258);
        applyStimulus(127); checkOutput("pos clamp", 32767);
        applyStimulus(0); checkOutput("flush c1", 32767);
        applyStimulus(0); checkOutput("flush c2", 32258);
        applyStimulus(0); checkOutput("flush c3", 16129);
        applyStimulus(0); checkOutput("flush c4", 0);
        applyStimulus(-128); checkOutput("neg 1", -16256);
        applyStimulus(-128); checkOutput("neg 2", -32512);
        applyStimulus(-128); checkOutput("neg clamp", -32768);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(0); checkOutput("held result", -32768);
        for (int i = 0; i < 6; i++) begin
            in_valid = (i % 2 == 0);
            x_in     = 8'd100;
            compare("held out_valid", int'(out_valid), 1);
            compare("held y_out", int'($signed(y_out)), -32768);
            compare("held in_ready", int'(in_ready), 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        compare("consumed out_valid", int'(out_valid), 0);
        applyStimulus(0); checkOutput("after backpressure", -32512);

        $display("[TB] reset during MAC");
        applyStimulus(5);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        compare("abort y_out", int'($signed(y_out)), 0);
        compare("abort out_valid", int'(out_valid), 0);
        compare("abort in_ready", int'(in_ready), 1);
        compare("abort busy", int'(busy), 0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        applyStimulus(3); checkOutput("zeroed coefficients", 0);
        for (int k = 0; k < N_TAPS; k++) writeCoef(k, 1);
        applyStimulus(0); checkOutput("cleared delay line", 3);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
